// File: rtl/cfg_write_arbiter_if.sv
// Two-port configuration write bus: SPI decoder (port 0) and local sequencer (port 1).
interface cfg_write_arbiter_if;
  logic       wr0_valid;
  logic       wr0_ready;
  logic [6:0] wr0_addr;
  logic [7:0] wr0_data;
  logic       wr1_valid;
  logic       wr1_ready;
  logic [6:0] wr1_addr;
  logic [7:0] wr1_data;

  modport master (
    output wr0_valid, wr0_addr, wr0_data,
    output wr1_valid, wr1_addr, wr1_data,
    input  wr0_ready, wr1_ready
  );

  modport slave (
    input  wr0_valid, wr0_addr, wr0_data,
    input  wr1_valid, wr1_addr, wr1_data,
    output wr0_ready, wr1_ready
  );
endinterface

// File: rtl/cfg_write_arbiter.sv
// Round-robin write arbiter for the PWM/output configuration bank.
// Writes land in shadow registers; the active bank is loaded from shadow
// only at a frame boundary so the PWM generator never sees a partial update.
module cfg_write_arbiter #(
  parameter int unsigned NUM_REGS = 5,
  parameter int unsigned DROP_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  cfg_write_arbiter_if.slave wr,
  input  logic              frame_sync,
  output logic [7:0]        en_out_7_0,
  output logic [7:0]        en_out_15_8,
  output logic [7:0]        en_pwm_7_0,
  output logic [7:0]        en_pwm_15_8,
  output logic [7:0]        duty,
  output logic              pending,
  output logic              commit,
  output logic [DROP_W-1:0] drop_count
);

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

  localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);

  port_e             rr_q, rr_d;
  logic [7:0]        shadow_q [NUM_REGS];
  logic [7:0]        shadow_d [NUM_REGS];
  logic [7:0]        active_q [NUM_REGS];
  logic [7:0]        active_d [NUM_REGS];
  logic              dirty_q, dirty_d;
  logic              commit_q, commit_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic       acc0, acc1, acc_any;
  logic [6:0] acc_addr;
  logic [7:0] acc_data;
  logic       hit, miss, do_commit;

  // Grant: uncontended requests win outright, contention resolved by rr_q; no grant in reset.
  always_comb begin
    wr.wr0_ready = rst_n & wr.wr0_valid & (~wr.wr1_valid | (rr_q == PORT0));
    wr.wr1_ready = rst_n & wr.wr1_valid & (~wr.wr0_valid | (rr_q == PORT1));
  end

  // Select the accepted write and classify it as implemented or dropped.
  always_comb begin
    acc0     = wr.wr0_valid & wr.wr0_ready;
    acc1     = wr.wr1_valid & wr.wr1_ready;
    acc_any  = acc0 | acc1;
    acc_addr = acc0 ? wr.wr0_addr : wr.wr1_addr;
    acc_data = acc0 ? wr.wr0_data : wr.wr1_data;
    hit      = acc_any & (acc_addr < NUM_REGS_A);
    miss     = acc_any & ~(acc_addr < NUM_REGS_A);
  end

  // Next-state: shadow write, commit of next-state shadow, pointer and drop counter.
  always_comb begin
    rr_d     = rr_q;
    shadow_d = shadow_q;
    active_d = active_q;
    dirty_d  = dirty_q;
    drop_d   = drop_q;

    if (acc_any) rr_d = acc0 ? PORT1 : PORT0;

    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (hit && acc_addr == 7'(i)) shadow_d[i] = acc_data;
    end

    // Commit sees shadow_d so a write accepted on the frame_sync cycle goes straight to active.
    do_commit = frame_sync & (dirty_q | hit);
    if (do_commit) begin
      active_d = shadow_d;
      dirty_d  = 1'b0;
    end else if (hit) begin
      dirty_d  = 1'b1;
    end
    commit_d = do_commit;

    if (miss && drop_q != '1) drop_d = drop_q + 1'b1;
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= PORT0;
      dirty_q  <= 1'b0;
      commit_q <= 1'b0;
      drop_q   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      rr_q     <= rr_d;
      dirty_q  <= dirty_d;
      commit_q <= commit_d;
      drop_q   <= drop_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // Output mapping of the active bank.
  always_comb begin
    en_out_7_0  = active_q[0];
    en_out_15_8 = active_q[1];
    en_pwm_7_0  = active_q[2];
    en_pwm_15_8 = active_q[3];
    duty        = active_q[4];
    pending     = dirty_q;
    commit      = commit_q;
    drop_count  = drop_q;
  end

endmodule
